// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   NOP_WORD_DEFAULT : instruction shown to decode when the queue is empty
//   PC_STEP          : byte distance to the next sequential instruction
//   fetch_entry_t    : one queued {pc, instr} pair
package fetch_pkg;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch/decode handshake bundle for instruction_fetch_queue.
//   master : fetch + decode side (drives PCIn/Instruction/FetchValid/DecodeReady/Flush)
//   slave  : the queue (drives PCWrite and the head-entry outputs plus Count)
interface instruction_fetch_queue_if #(parameter int DEPTH = 2);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   PCIn;
  logic [31:0]   Instruction;
  logic          FetchValid;
  logic          PCWrite;
  logic          DecodeReady;
  logic          Flush;
  logic [31:0]   OutPC;
  logic [31:0]   OutPCPlus4;
  logic [31:0]   OutInstruction;
  logic          OutValid;
  logic [CW-1:0] Count;

  modport master (
    output PCIn, Instruction, FetchValid, DecodeReady, Flush,
    input  PCWrite, OutPC, OutPCPlus4, OutInstruction, OutValid, Count
  );

  modport slave (
    input  PCIn, Instruction, FetchValid, DecodeReady, Flush,
    output PCWrite, OutPC, OutPCPlus4, OutInstruction, OutValid, Count
  );
endinterface

// File: rtl/instruction_fetch_queue_storage.sv
// fetch_queue_storage: DEPTH x 64-bit entry array for the fetch queue.
//   Clock         : write clock
//   we/waddr/wdata: synchronous write port
//   raddr/rdata   : asynchronous read port (head entry)
// Contents are not reset; the top masks the read data whenever the queue is empty.
module fetch_queue_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          Clock,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  fetch_entry_t  wdata,
  input  logic [PW-1:0] raddr,
  output fetch_entry_t  rdata
);
  fetch_entry_t mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: fetch-to-decode FIFO sitting right after the PC.
//   Clock, Reset : rising-edge clock, async active-low reset
//   bus (slave)  : PCIn/Instruction/FetchValid in, PCWrite out (PC enable),
//                  DecodeReady/Flush in, OutPC/OutPCPlus4/OutInstruction/OutValid/Count out
//   StallCount   : only with INSTRUCTION_FETCH_QUEUE_STATS_EN; saturating count of
//                  cycles where a valid fetch was refused because the queue was full
// Flush beats everything: pointers and count clear at the next edge and any
// same-cycle enqueue/dequeue is dropped. PCWrite depends only on registered count.
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic                      Clock,
  input  logic                      Reset,
  instruction_fetch_queue_if.slave  bus
`ifdef INSTRUCTION_FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]               StallCount
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, enq, deq;
  fetch_entry_t  wr_entry, head;
  logic [31:0]   out_pc;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign enq   = bus.FetchValid && !full && !bus.Flush;
  assign deq   = !empty && bus.DecodeReady && !bus.Flush;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign wr_entry = '{pc: bus.PCIn, instr: bus.Instruction};

  fetch_queue_storage #(.DEPTH(DEPTH)) u_storage (
    .Clock (Clock),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Empty queue presents a NOP at PC 0 so decode never sees stale storage.
  assign out_pc             = empty ? 32'h0 : head.pc;
  assign bus.OutPC          = out_pc;
  assign bus.OutPCPlus4     = out_pc + PC_STEP;
  assign bus.OutInstruction = empty ? NOP_WORD : head.instr;
  assign bus.OutValid       = !empty;
  assign bus.PCWrite        = !full;
  assign bus.Count          = count;

`ifdef INSTRUCTION_FETCH_QUEUE_STATS_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      StallCount <= '0;
    else if (bus.FetchValid && full && !bus.Flush && StallCount != 16'hFFFF)
      StallCount <= StallCount + 16'd1;
  end
`endif
endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Fetch-to-decode buffer directly downstream of the program counter. Each cycle it captures the current PC and the instruction word read from instruction memory at that PC into a small FIFO. It presents the oldest entry to the decode stage with a valid/ready handshake. It drives the PC register's write enable, so the PC holds whenever the queue cannot accept another entry, and it discards all queued entries on a branch/jump flush.

## Interface
Parameters:
- DEPTH, 2, number of queue entries; a power of two, minimum 2.
- NOP_WORD, 32'h00000000, instruction value driven on OutInstruction when the queue is empty.

Ports:
- Clock  in  1  single clock for all state; everything updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- PCIn  in  32  current PC value (the PC register output).
- Instruction  in  32  instruction memory read data for PCIn.
- FetchValid  in  1  PCIn/Instruction pair is valid this cycle.
- PCWrite  out  1  write enable to the PC register; high means the PC may advance.
- DecodeReady  in  1  decode stage accepts the head entry this cycle.
- Flush  in  1  branch/jump taken; discard every queued entry.
- OutPC  out  32  PC of the head entry.
- OutPCPlus4  out  32  OutPC + 4, modulo 2^32.
- OutInstruction  out  32  instruction word of the head entry.
- OutValid  out  1  head entry is valid.
- Count  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: DEPTH entries of {pc[31:0], instr[31:0]}, with read/write pointers of log2(DEPTH) bits that wrap naturally, plus an occupancy counter.
- Full = (Count == DEPTH). Empty = (Count == 0).
- PCWrite = !Full. It depends on registered state only; there is no combinational path from DecodeReady or Flush.
- Enqueue when FetchValid && !Full && !Flush. The entry is written at the write pointer, which then increments.
- Dequeue when OutValid && DecodeReady && !Flush. The read pointer increments.
- Simultaneous enqueue and dequeue leaves Count unchanged. This is legal when not full.
- FetchValid while Full: the pair is ignored. The PC is already held because PCWrite is low, so the same pair is re-presented next cycle.
- Flush takes priority over everything. At the next edge both pointers and Count are cleared, and any same-cycle enqueue or dequeue is dropped.
- Outputs:
  - OutValid = !Empty.
  - When Empty: OutInstruction = NOP_WORD, OutPC = 0, OutPCPlus4 = 4.
  - Otherwise the outputs show the head entry.
- Output values are combinational from the registered storage. There is no write-to-read bypass.

## Timing
- Reset (asynchronous, Reset low): pointers = 0, Count = 0, OutValid = 0, PCWrite = 1, OutPC = 0, OutPCPlus4 = 4, OutInstruction = NOP_WORD, StallCount = 0.
- Latency: a pair enqueued at edge N appears on the outputs after edge N (visible during cycle N+1) if the queue was empty.
- Throughput: one entry per cycle in and out in steady state.
- PCWrite falls in the cycle after the enqueue that fills the queue. It rises in the cycle after the first dequeue or flush from full.
- Reset asserted mid-operation clears all state immediately. Reset release is sampled synchronously by the downstream logic only.

## Configuration
- INSTRUCTION_FETCH_QUEUE_STATS_EN
  - Defined: adds output StallCount[15:0]. It increments on every cycle with FetchValid && Full && !Flush and saturates at 16'hFFFF. It is cleared only by reset.
  - Undefined: the StallCount port and its logic are absent, and all other behaviour is identical.

## Structure
- Shared package fetch_pkg holds:
  - the NOP_WORD default constant;
  - a fetch_entry_t struct {pc, instr};
  - a PC_STEP = 4 constant.
- One sub-module, fetch_queue_storage: the DEPTH×64-bit register array with write port and asynchronous read port. The top level owns the pointers, count, handshake and flush logic.

## Test plan
- Reset low mid-stream with Count = 2 -> OutValid = 0, Count = 0, PCWrite = 1, OutInstruction = 32'h00000000 immediately, with no clock edge.
- FetchValid = 1, PCIn = 0x10, Instruction = 0x8C080004, DecodeReady = 0, for two cycles -> Count = 2, PCWrite = 0, OutPC = 0x10, OutPCPlus4 = 0x14.
- Queue full, FetchValid held, DecodeReady pulsed for one cycle -> one dequeue. PCWrite returns to 1 the next cycle, Count goes 2 -> 1 -> 2, and entry order is preserved.
- Continuous FetchValid and DecodeReady with PCIn stepping 0, 4, 8 -> OutPC stepping 0, 4, 8, one cycle behind, with Count steady at 1.
- Flush asserted with Count = 2 and FetchValid = 1 in the same cycle -> Count = 0 and OutValid = 0 after the edge, and the flushed-cycle pair is not stored.
- With INSTRUCTION_FETCH_QUEUE_STATS_EN defined: hold full with FetchValid for 5 cycles -> StallCount = 5. Force 70000 stall cycles -> StallCount = 16'hFFFF.
